// File: rtl/pe_accum_sequencer_pkg.sv
// Shared PE types used by pe_accum_sequencer: accumulator-sequencer state
// encoding, the pipeline latency config, and helpers that turn a config into
// the sequencer's strobe delays.
package pe_types;

  typedef enum logic {
    IDLE,
    ISSUE
  } accum_seq_state_t;

  typedef struct packed {
    int unsigned ram_latency;
    int unsigned dot_latency;
    int unsigned accum_latency;
  } pe_cfg_t;

  localparam pe_cfg_t PE_CFG_DEFAULT = '{ram_latency: 1, dot_latency: 2, accum_latency: 9};

  // Cycles from a term's valid to its dot output reaching the accumulator.
  function automatic int unsigned accum_seq_flush_delay(input pe_cfg_t cfg);
    return cfg.ram_latency + cfg.dot_latency;
  endfunction

  // Cycles from flush at the accumulator input to its result being visible.
  function automatic int unsigned accum_seq_result_delay(input pe_cfg_t cfg);
    return cfg.accum_latency;
  endfunction

endpackage

// File: rtl/pe_accum_sequencer_delay.sv
// delay: DEPTH-stage shift register with synchronous active-high reset.
// DEPTH = 0 degenerates to a wire.
module delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_wire
    assign o_data = i_data;
  end else begin : g_pipe
    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    // Shift the input one stage per cycle.
    always_comb begin
      pipe_d[0] = i_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    // Pipeline registers, cleared by reset.
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign o_data = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/pe_accum_sequencer.sv
// pe_accum_sequencer: issues per-term valids for one column accumulator,
// generates the aligned flush and result-valid strobes and tracks groups in
// flight. Optional sticky zero-length error flag: PE_ACCUM_SEQ_ERRCHK_EN.
module pe_accum_sequencer
  import pe_types::*;
#(
  parameter int unsigned LEN_WIDTH    = 16,
  parameter int unsigned FLUSH_DELAY  = accum_seq_flush_delay(PE_CFG_DEFAULT),
  parameter int unsigned RESULT_DELAY = accum_seq_result_delay(PE_CFG_DEFAULT)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [LEN_WIDTH-1:0] i_cmd_len,
  input  logic                 i_feed_ok,
  output logic                 o_valid,
  output logic                 o_flush,
  output logic                 o_result_valid,
  output logic                 o_busy,
  output logic                 o_error
);

  localparam int unsigned INFL_W = $clog2(FLUSH_DELAY + RESULT_DELAY + 2);

  accum_seq_state_t     state_q, state_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [INFL_W-1:0]    inflight_q, inflight_d;

  logic cmd_ready;
  logic cmd_accept;
  logic len_zero;
  logic issue;
  logic last_issue;
  logic flush;
  logic result_valid;

  assign len_zero = (i_cmd_len == '0);

  // Next state, term countdown and command handshake; a command accepted on
  // the last-issue cycle overrides the return to IDLE so groups chain
  // without a bubble. Reset gates all strobes and the handshake.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cmd_ready   = 1'b0;
    issue       = 1'b0;
    last_issue  = 1'b0;
    case (state_q)
      IDLE: cmd_ready = 1'b1;
      ISSUE: begin
        issue      = i_feed_ok;
        last_issue = i_feed_ok && (remaining_q == LEN_WIDTH'(1));
        cmd_ready  = last_issue;
        if (i_feed_ok) remaining_d = remaining_q - LEN_WIDTH'(1);
        if (last_issue) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cmd_ready  = cmd_ready && !reset;
    issue      = issue && !reset;
    last_issue = last_issue && !reset;
    cmd_accept = i_cmd_valid && cmd_ready;
    if (cmd_accept && !len_zero) begin
      remaining_d = i_cmd_len;
      state_d     = ISSUE;
    end
  end

  // Groups in flight: +1 on last issue, -1 when its result lands.
  always_comb begin
    inflight_d = inflight_q;
    if (last_issue && !result_valid) inflight_d = inflight_q + INFL_W'(1);
    else if (!last_issue && result_valid) inflight_d = inflight_q - INFL_W'(1);
  end

  // State, countdown and in-flight registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
    end
  end

  delay #(.WIDTH(1), .DEPTH(FLUSH_DELAY)) u_flush_dly (
    .clock  (clock),
    .reset  (reset),
    .i_data (last_issue),
    .o_data (flush)
  );

  delay #(.WIDTH(1), .DEPTH(RESULT_DELAY)) u_result_dly (
    .clock  (clock),
    .reset  (reset),
    .i_data (flush),
    .o_data (result_valid)
  );

`ifdef PE_ACCUM_SEQ_ERRCHK_EN
  logic error_q, error_d;

  // Sticky flag for any accepted zero-length command.
  always_comb error_d = error_q || (cmd_accept && len_zero);

  // Error register, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) error_q <= 1'b0;
    else       error_q <= error_d;
  end

  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

  assign o_cmd_ready    = cmd_ready;
  assign o_valid        = issue;
  assign o_flush        = flush;
  assign o_result_valid = result_valid;
  assign o_busy         = (state_q == ISSUE) || (inflight_q != '0);

endmodule

// File: tb/tb_pe_accum_sequencer.sv
// Scoreboard bench for pe_accum_sequencer: per-cycle tables give inputs and
// expected level outputs; expected flush/result cycles are queued when a
// scenario is launched and popped as the strobes appear.
module tb_pe_accum_sequencer;

  localparam int unsigned LW = 16;
`ifdef PE_ACCUM_SEQ_ERRCHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [LW-1:0] i_cmd_len;
  logic          i_feed_ok;
  logic          o_valid;
  logic          o_flush;
  logic          o_result_valid;
  logic          o_busy;
  logic          o_error;

  int n_checks = 0;
  int n_fail   = 0;
  int flush_q[$];
  int res_q[$];

  pe_accum_sequencer #(.LEN_WIDTH(LW), .FLUSH_DELAY(3), .RESULT_DELAY(9)) dut (
    .clock          (clock),
    .reset          (reset),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_len      (i_cmd_len),
    .i_feed_ok      (i_feed_ok),
    .o_valid        (o_valid),
    .o_flush        (o_flush),
    .o_result_valid (o_result_valid),
    .o_busy         (o_busy),
    .o_error        (o_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One scenario: bit t of each vector applies to relative cycle Tt.
  task automatic run(input string name, input int ncyc,
                     input logic [63:0] cv, input logic [63:0] fo, input logic [63:0] rst,
                     input logic [LW-1:0] len,
                     input logic [63:0] ev, input logic [63:0] erdy,
                     input logic [63:0] ebusy, input logic [63:0] eerr);
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clock);
      reset       = rst[t];
      i_cmd_valid = cv[t];
      i_feed_ok   = fo[t];
      i_cmd_len   = len;
      #1;
      check_val($sformatf("%s.valid@T%0d", name, t), o_valid, ev[t]);
      check_val($sformatf("%s.ready@T%0d", name, t), o_cmd_ready, erdy[t]);
      check_val($sformatf("%s.busy@T%0d", name, t), o_busy, ebusy[t]);
      check_val($sformatf("%s.error@T%0d", name, t), o_error, eerr[t]);
      if (o_flush) begin
        if (flush_q.size() > 0) check_val($sformatf("%s.flush_cyc", name), t, flush_q.pop_front());
        else check_val($sformatf("%s.flush_unexp@T%0d", name, t), o_flush, 0);
      end
      if (o_result_valid) begin
        if (res_q.size() > 0) check_val($sformatf("%s.result_cyc", name), t, res_q.pop_front());
        else check_val($sformatf("%s.result_unexp@T%0d", name, t), o_result_valid, 0);
      end
    end
    check_val($sformatf("%s.flush_missing", name), flush_q.size(), 0);
    check_val($sformatf("%s.result_missing", name), res_q.size(), 0);
    flush_q.delete();
    res_q.delete();
  endtask

  initial begin
    reset       = 1'b1;
    i_cmd_valid = 1'b1;
    i_cmd_len   = LW'(5);
    i_feed_ok   = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      #1;
      check_val("rst.ready", o_cmd_ready, 0);
      check_val("rst.valid", o_valid, 0);
      check_val("rst.flush", o_flush, 0);
      check_val("rst.result", o_result_valid, 0);
      check_val("rst.busy", o_busy, 0);
      check_val("rst.error", o_error, 0);
    end
    @(negedge clock);
    reset       = 1'b0;
    i_cmd_valid = 1'b0;
    #1;
    check_val("rst.ready_after", o_cmd_ready, 1);
    check_val("rst.busy_after", o_busy, 0);

    // len 4, continuous feed
    flush_q.push_back(7);  res_q.push_back(16);
    run("len4", 20, 64'h1, '1, '0, LW'(4),
        64'h1E, ~64'hE, 64'h1FFFE, '0);

    // len 4 with feed bubbles at T2-T3
    flush_q.push_back(9);  res_q.push_back(18);
    run("bubble", 22, 64'h1, ~64'hC, '0, LW'(4),
        64'h72, ~64'h3E, 64'h7FFFE, '0);

    // three back-to-back len 1 groups
    flush_q.push_back(4);  flush_q.push_back(5);  flush_q.push_back(6);
    res_q.push_back(13);   res_q.push_back(14);   res_q.push_back(15);
    run("len1x3", 20, 64'h7, '1, '0, LW'(1),
        64'hE, '1, 64'hFFFE, '0);

    // len 8 abandoned by reset at T3
    run("midrst", 31, 64'h1, '1, 64'h8, LW'(8),
        64'h6, ~64'hE, 64'hE, '0);

    // zero-length command
    run("len0", 6, 64'h1, '1, '0, LW'(0),
        '0, '1, '0, ERR_EN ? ~64'h1 : 64'h0);

    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_val("final.error_cleared", o_error, 0);
    check_val("final.busy", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
